// File: rtl/pupil_centroid_if.sv
// Pixel-stream bundle between the grayscale stage, the centroid block and the display path.
// Signal names follow the camera pipeline's existing i*/o* naming.
interface pupil_centroid_if;
   logic        iDVAL;
   logic [9:0]  iDATA;
   logic [12:0] iH_Cont;
   logic [12:0] iV_Cont;
   logic [9:0]  iThresh;
   logic        iMaskEn;
   logic        oDVAL;
   logic [9:0]  oDATA;
   logic [12:0] oX;
   logic [12:0] oY;
   logic        oFound;
   logic        oValid;
   logic        oBusy;

   modport master (
      output iDVAL, iDATA, iH_Cont, iV_Cont, iThresh, iMaskEn,
      input  oDVAL, oDATA, oX, oY, oFound, oValid, oBusy
   );

   modport slave (
      input  iDVAL, iDATA, iH_Cont, iV_Cont, iThresh, iMaskEn,
      output oDVAL, oDATA, oX, oY, oFound, oValid, oBusy
   );
endinterface

// File: rtl/pupil_centroid.sv
// Dark-pixel centroid of a fixed ROI, one result per frame, plus a 1-cycle binarized/passthrough
// display stream.
//
// state | meaning
// IDLE  | accumulating, waiting for a frame boundary
// DIV_X | restoring divide sumX / cnt, one quotient bit per cycle
// DIV_Y | restoring divide sumY / cnt, one quotient bit per cycle
// DONE  | publish result, pulse oValid
module pupil_centroid #(
   parameter int ROI_X0  = 0,
   parameter int ROI_X1  = 1279,
   parameter int ROI_Y0  = 0,
   parameter int ROI_Y1  = 959,
   parameter int MIN_PIX = 64
) (
   input logic             iCLK,
   input logic             iRST,
   pupil_centroid_if.slave pix
);

   typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;

   // Offset compare keeps the ROI test free of constant-true comparisons when ROI_X0/ROI_Y0 are 0.
   localparam logic [12:0] X0      = 13'(ROI_X0);
   localparam logic [12:0] XW      = 13'(ROI_X1 - ROI_X0);
   localparam logic [12:0] Y0      = 13'(ROI_Y0);
   localparam logic [12:0] YW      = 13'(ROI_Y1 - ROI_Y0);
   localparam logic [23:0] MIN_CNT = 24'(MIN_PIX);
   localparam logic [5:0]  LAST_IT = 6'd35;

   state_t      state_q;
   logic [12:0] prev_v_q;
   logic [35:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
   logic [23:0] cnt_q, cnt_d;
   logic [35:0] snap_y_q;
   logic [23:0] div_q;
   logic        found_q;
   logic [35:0] quo_q, quo_d, qx_q;
   logic [23:0] rem_q, rem_d;
   logic [24:0] rem_sh;
   logic [5:0]  it_q;
   logic        ge;
   logic        in_roi, dark, boundary;

   logic        dval_q, found_o_q, valid_q, busy_q;
   logic [9:0]  data_q;
   logic [12:0] x_q, y_q;

   function automatic logic [12:0] sat13(input logic [35:0] q);
      return (|q[35:13]) ? 13'h1FFF : q[12:0];
   endfunction

   assign in_roi   = (13'(pix.iH_Cont - X0) <= XW) && (13'(pix.iV_Cont - Y0) <= YW);
   assign dark     = pix.iDVAL && (pix.iDATA < pix.iThresh) && in_roi;
   assign boundary = pix.iDVAL && (pix.iV_Cont < prev_v_q);

   // The boundary pixel opens the new frame, so it restarts the sums with its own contribution.
   always_comb begin
      sum_x_d = boundary ? '0 : sum_x_q;
      sum_y_d = boundary ? '0 : sum_y_q;
      cnt_d   = boundary ? '0 : cnt_q;
      if (dark) begin
         sum_x_d = sum_x_d + 36'(pix.iH_Cont);
         sum_y_d = sum_y_d + 36'(pix.iV_Cont);
         cnt_d   = cnt_d + 24'd1;
      end
   end

   always_comb begin
      rem_sh = {rem_q, quo_q[35]};
      ge     = rem_sh >= {1'b0, div_q};
      rem_d  = ge ? 24'(rem_sh - {1'b0, div_q}) : rem_sh[23:0];
      quo_d  = {quo_q[34:0], ge};
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         dval_q   <= 1'b0;
         data_q   <= '0;
         prev_v_q <= '0;
         sum_x_q  <= '0;
         sum_y_q  <= '0;
         cnt_q    <= '0;
      end else begin
         dval_q  <= pix.iDVAL;
         data_q  <= pix.iMaskEn ? (dark ? 10'd0 : 10'h3FF) : pix.iDATA;
         sum_x_q <= sum_x_d;
         sum_y_q <= sum_y_d;
         cnt_q   <= cnt_d;
         if (pix.iDVAL) prev_v_q <= pix.iV_Cont;
      end
   end

   // Snapshot/divisor only load from IDLE, so a boundary during a division cannot disturb it.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state_q   <= IDLE;
         snap_y_q  <= '0;
         div_q     <= '0;
         found_q   <= 1'b0;
         quo_q     <= '0;
         qx_q      <= '0;
         rem_q     <= '0;
         it_q      <= '0;
         x_q       <= '0;
         y_q       <= '0;
         found_o_q <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (boundary) begin
                  snap_y_q <= sum_y_q;
                  div_q    <= cnt_q;
                  found_q  <= (cnt_q >= MIN_CNT);
                  quo_q    <= sum_x_q;
                  rem_q    <= '0;
                  it_q     <= LAST_IT;
                  busy_q   <= 1'b1;
                  state_q  <= (cnt_q >= MIN_CNT) ? DIV_X : DONE;
               end
            end
            DIV_X: begin
               if (it_q == 6'd0) begin
                  qx_q    <= quo_d;
                  quo_q   <= snap_y_q;
                  rem_q   <= '0;
                  it_q    <= LAST_IT;
                  state_q <= DIV_Y;
               end else begin
                  quo_q <= quo_d;
                  rem_q <= rem_d;
                  it_q  <= it_q - 6'd1;
               end
            end
            DIV_Y: begin
               quo_q <= quo_d;
               rem_q <= rem_d;
               if (it_q == 6'd0) state_q <= DONE;
               else              it_q    <= it_q - 6'd1;
            end
            DONE: begin
               valid_q   <= 1'b1;
               found_o_q <= found_q;
               if (found_q) begin
                  x_q <= sat13(qx_q);
                  y_q <= sat13(quo_q);
               end
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign pix.oDVAL  = dval_q;
   assign pix.oDATA  = data_q;
   assign pix.oX     = x_q;
   assign pix.oY     = y_q;
   assign pix.oFound = found_o_q;
   assign pix.oValid = valid_q;
   assign pix.oBusy  = busy_q;

endmodule

// File: tb/tb_pupil_centroid.sv
// Directed bench for pupil_centroid: pixel path, centroid, ROI/threshold edges,
// below-minimum frames, overlapping boundaries and reset during division.
module tb_pupil_centroid;

   logic iCLK = 1'b0;
   logic iRST = 1'b0;
   always #5 iCLK = ~iCLK;

   pupil_centroid_if pix ();

   pupil_centroid #(
      .ROI_X0(10), .ROI_X1(1279), .ROI_Y0(5), .ROI_Y1(959), .MIN_PIX(16)
   ) dut (
      .iCLK (iCLK),
      .iRST (iRST),
      .pix  (pix)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int vcnt  = 0;
   int vcyc  = 0;
   int bcyc  = 0;

   always @(posedge iCLK) cyc <= cyc + 1;
   always @(negedge iCLK) if (pix.oValid) begin
      vcnt <= vcnt + 1;
      vcyc <= cyc;
   end

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge iCLK);
      #1;
   endtask

   task automatic drv(input logic dv, input logic [9:0] d, input logic [12:0] h, input logic [12:0] v);
      pix.iDVAL   = dv;
      pix.iDATA   = d;
      pix.iH_Cont = h;
      pix.iV_Cont = v;
      step();
   endtask

   task automatic boundary();
      drv(1'b1, 10'd200, 13'd0, 13'd0);
      bcyc = cyc;
   endtask

   // 4x4 dark block at (x0,y0), first n pixels only, interleaved with bright pixels.
   task automatic block(input int x0, input int y0, input int n);
      int k = 0;
      for (int y = 0; y < 4; y++) begin
         for (int x = 0; x < 4; x++) begin
            if (k < n) drv(1'b1, 10'd20, 13'(x0 + x), 13'(y0 + y));
            k++;
         end
         drv(1'b1, 10'd200, 13'(x0 + 8), 13'(y0 + y));
      end
   endtask

   task automatic wait_res(input string tag, input int lat_exp);
      int v0 = vcnt;
      int k  = 0;
      pix.iDVAL = 1'b0;
      while (vcnt == v0 && k < 300) begin
         step();
         k++;
      end
      chk({tag, "_seen"}, 36'(vcnt != v0), 36'd1);
      chk({tag, "_lat"}, 36'(vcyc - bcyc), 36'(lat_exp));
   endtask

   task automatic chk_res(input string tag, input int x, input int y, input logic f);
      chk({tag, "_x"}, 36'(pix.oX), 36'(x));
      chk({tag, "_y"}, 36'(pix.oY), 36'(y));
      chk({tag, "_found"}, 36'(pix.oFound), 36'(f));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_x"}, 36'(pix.oX), 36'd0);
      chk({tag, "_y"}, 36'(pix.oY), 36'd0);
      chk({tag, "_found"}, 36'(pix.oFound), 36'd0);
      chk({tag, "_valid"}, 36'(pix.oValid), 36'd0);
      chk({tag, "_busy"}, 36'(pix.oBusy), 36'd0);
      chk({tag, "_dval"}, 36'(pix.oDVAL), 36'd0);
      chk({tag, "_data"}, 36'(pix.oDATA), 36'd0);
   endtask

   initial begin
      int v0;
      pix.iDVAL   = 1'b0;
      pix.iDATA   = '0;
      pix.iH_Cont = '0;
      pix.iV_Cont = '0;
      pix.iThresh = 10'd50;
      pix.iMaskEn = 1'b1;
      repeat (3) step();
      chk_zero("rst");
      iRST = 1'b1;
      step();

      // pixel path
      drv(1'b1, 10'd10, 13'd200, 13'd300);
      chk("mask_dark", 36'(pix.oDATA), 36'd0);
      chk("mask_dval", 36'(pix.oDVAL), 36'd1);
      drv(1'b1, 10'd50, 13'd201, 13'd300);
      chk("mask_eq_thr", 36'(pix.oDATA), 36'd1023);
      pix.iMaskEn = 1'b0;
      drv(1'b0, 10'd345, 13'd202, 13'd300);
      chk("pass_data", 36'(pix.oDATA), 36'd345);
      chk("pass_dval", 36'(pix.oDVAL), 36'd0);
      pix.iMaskEn = 1'b1;

      // partial first frame holds a single dark pixel
      boundary();
      wait_res("flush", 1);
      chk_res("flush", 0, 0, 1'b0);

      // 4x4 block: sumX 1624, sumY 3224, cnt 16
      block(100, 200, 16);
      boundary();
      repeat (10) step();
      chk("blk_busy", 36'(pix.oBusy), 36'd1);
      wait_res("blk", 73);
      chk_res("blk", 101, 201, 1'b1);
      chk("blk_idle", 36'(pix.oBusy), 36'd0);

      // ROI/threshold edges: only (1279,203) is added; sumX 2800 / 16 = 175
      block(100, 200, 15);
      drv(1'b1, 10'd20, 13'd9,    13'd203);
      drv(1'b1, 10'd20, 13'd1280, 13'd203);
      drv(1'b1, 10'd50, 13'd110,  13'd203);
      drv(1'b1, 10'd20, 13'd1279, 13'd203);
      boundary();
      wait_res("edge", 73);
      chk_res("edge", 175, 201, 1'b1);

      // 15 dark pixels: below minimum, position held
      block(100, 200, 15);
      boundary();
      wait_res("low", 1);
      chk_res("low", 175, 201, 1'b0);

      // second boundary 20 cycles into the division discards that frame
      block(100, 200, 16);
      boundary();
      for (int i = 0; i < 19; i++) drv(1'b1, 10'd20, 13'(500 + i), 13'd600);
      drv(1'b1, 10'd200, 13'd0, 13'd0);
      wait_res("ovl1", 73);
      chk_res("ovl1", 101, 201, 1'b1);
      v0 = vcnt;
      repeat (80) step();
      chk("ovl_no_extra", 36'(vcnt), 36'(v0));
      block(300, 400, 16);
      boundary();
      wait_res("ovl3", 73);
      chk_res("ovl3", 301, 401, 1'b1);

      // reset mid-division with random stimulus
      block(100, 200, 16);
      boundary();
      repeat (20) step();
      chk("rdiv_busy", 36'(pix.oBusy), 36'd1);
      iRST = 1'b0;
      for (int i = 0; i < 5; i++) begin
         pix.iMaskEn = 1'($urandom);
         pix.iThresh = 10'($urandom);
         drv(1'($urandom), 10'($urandom), 13'($urandom), 13'($urandom));
      end
      chk_zero("rdiv");
      pix.iDVAL   = 1'b0;
      pix.iMaskEn = 1'b1;
      pix.iThresh = 10'd50;
      iRST = 1'b1;
      v0 = vcnt;
      repeat (100) step();
      chk("rdiv_no_valid", 36'(vcnt), 36'(v0));
      block(300, 400, 16);
      boundary();
      wait_res("rdiv_next", 73);
      chk_res("rdiv_next", 301, 401, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/pupil_centroid.md
Name: pupil_centroid

Overview:
- Sits directly downstream of the grayscale/overlay stage in the pupil-search camera pipeline.
- Consumes the 10-bit grayscale pixel stream together with its H/V counters.
- Thresholds dark pixels inside a fixed region of interest (ROI) and accumulates their coordinates and count per frame.
- At each frame boundary, computes the dark-blob centroid with a sequential divider; also emits a 1-cycle-latency binarized or passthrough pixel stream for display.

Parameters:
- ROI_X0, 0, first ROI column (inclusive)
- ROI_X1, 1279, last ROI column (inclusive)
- ROI_Y0, 0, first ROI row (inclusive)
- ROI_Y1, 959, last ROI row (inclusive)
- MIN_PIX, 64, minimum dark-pixel count for a valid centroid; must be >= 1

Ports:
- iCLK  in  1  pixel clock
- iRST  in  1  reset, asynchronous, active-low
- iDVAL  in  1  input pixel valid
- iDATA  in  10  grayscale pixel
- iH_Cont  in  13  column of current pixel
- iV_Cont  in  13  row of current pixel
- iThresh  in  10  dark threshold
- iMaskEn  in  1  1 = binarized output, 0 = grayscale passthrough
- oDVAL  out  1  registered iDVAL
- oDATA  out  10  output pixel
- oX  out  13  centroid column
- oY  out  13  centroid row
- oFound  out  1  last computed frame met MIN_PIX
- oValid  out  1  one-cycle pulse when oX/oY/oFound update
- oBusy  out  1  divider active

Behaviour:
- Reset (async, iRST low): all outputs 0; accumulators, snapshot, divider and prev-row register cleared; FSM to IDLE. Reset mid-division abandons the result, and no oValid is produced.
- Pixel path, latency 1:
  - oDVAL <= iDVAL every cycle.
  - With iMaskEn=1: oDATA <= 0 if dark, else 1023.
  - With iMaskEn=0: oDATA <= iDATA.
- Dark pixel: iDVAL=1 and iDATA < iThresh (strict) and ROI_X0 <= iH_Cont <= ROI_X1 and ROI_Y0 <= iV_Cont <= ROI_Y1.
- Accumulators:
  - sumX 36b += iH_Cont; sumY 36b += iV_Cont; cnt 24b += 1 on each dark pixel.
  - No wrap is possible within a 2^22-pixel frame.
- Frame boundary:
  - Occurs on a cycle with iDVAL=1 and iV_Cont < prevV. prevV updates only on iDVAL=1.
  - On the boundary edge, {sumX, sumY, cnt} are copied into the snapshot and the accumulators are loaded with the boundary pixel's contribution. That pixel belongs to the new frame.
- FSM:
  - IDLE: on boundary, if snapshot cnt >= MIN_PIX go to DIV_X; else go to DONE with found=0.
  - DIV_X: 36-iteration restoring division sumX/cnt, 1 quotient bit per cycle (36 cycles) -> DIV_Y.
  - DIV_Y: same for sumY/cnt (36 cycles) -> DONE.
  - DONE: one cycle.
    - Pulse oValid.
    - If found: load oX/oY from the quotient LSBs, truncated toward zero and saturated to 8191 if the quotient exceeds 13 bits; set oFound=1.
    - If not found: oFound=0 and oX/oY hold their previous values.
    - Return to IDLE.
- oBusy = 1 in DIV_X, DIV_Y and DONE.
- Timing: oValid is high exactly 73 cycles after the boundary edge for the found case, and 1 cycle after it for the not-found case.
- Boundary while oBusy=1: accumulators are still cleared and restarted, the finished frame's totals are discarded, and the divider continues unaffected.
- The first boundary after reset produces a result for the partial frame; this is acceptable.

Test Plan:
- Reset: hold iRST low mid-division with random stimulus -> all outputs 0, no oValid after release until a full frame plus boundary.
- Centroid: dark 4x4 block at x=100..103, y=200..203, iThresh=50, rest 200, MIN_PIX=16 -> cnt 16, sumX 1624, sumY 3224; oX=101, oY=201, oFound=1, oValid 73 cycles after boundary.
- Below minimum: same frame with MIN_PIX=17 -> oValid 1 cycle after boundary, oFound=0, oX/oY unchanged from previous frame.
- ROI/threshold edges: dark pixels at x=ROI_X0-1 and x=ROI_X1 -> only the latter counted; pixel equal to iThresh -> not counted.
- Pixel path: iMaskEn=1 with iDATA=10, iThresh=50 -> oDATA=0 next cycle; iDATA=50 -> 1023; iMaskEn=0 -> oDATA=iDATA delayed 1 cycle, oDVAL follows iDVAL.
- Overlapping boundary: force a second boundary 20 cycles after the first -> first result still delivered correctly, second frame's totals discarded, third frame computes normally.
